// File: rtl/srl_fifo_pkg.sv
// Shared constants for the SRL-based first-word-fall-through FIFO.
//   PTR_EMPTY_CODE : pointer value meaning "no words stored" (all ones);
//                    truncate to the pointer width where it is used.
//   MIN_DEPTH      : smallest capacity the controller supports.
package srl_fifo_pkg;

  localparam logic [31:0] PTR_EMPTY_CODE = '1;
  localparam int          MIN_DEPTH      = 2;

endpackage : srl_fifo_pkg

// File: rtl/srl_fifo_ctrl_if.sv
// Handshake bundle for srl_fifo_ctrl: producer write side, consumer read
// side and occupancy.
//   master : the agent using the FIFO (drives requests, enables, data in)
//   slave  : the FIFO itself (drives flags, head data, occupancy)
interface srl_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
);

  logic                  write_ce;
  logic                  write;
  logic [DATA_WIDTH-1:0] din;
  logic                  full_n;
  logic                  read_ce;
  logic                  read;
  logic [DATA_WIDTH-1:0] dout;
  logic                  empty_n;
  logic [ADDR_WIDTH:0]   usedw;

  modport master (
    output write_ce, write, din, read_ce, read,
    input  full_n, dout, empty_n, usedw
  );

  modport slave (
    input  write_ce, write, din, read_ce, read,
    output full_n, dout, empty_n, usedw
  );

endinterface : srl_fifo_ctrl_if

// File: rtl/srl_fifo_shiftreg.sv
// Storage for the SRL FIFO: a shift register with a random-access read tap.
// No reset -- contents are meaningful only where the controller says so.
//   clk  : clock
//   we   : shift enable; din enters index 0, older words move up one index
//   addr : read tap index
//   din  : word to insert
//   dout : word at index addr (combinational)
module srl_fifo_shiftreg #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  // Sized to the full address range so the tap is always in bounds, even
  // when the controller's empty code lands on an index beyond DEPTH-1.
  localparam int unsigned SLOTS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [SLOTS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = DEPTH - 1; i > 0; i--) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= din;
    end
  end

  assign dout = mem[addr];

endmodule : srl_fifo_shiftreg

// File: rtl/srl_fifo_ctrl.sv
// First-word-fall-through FIFO built on a shift register. The pointer tracks
// the index of the oldest word (all ones = empty, k = k+1 words), so the
// head is always at the shift register's read tap and appears on if_dout
// with zero read latency.
//   clk, reset_n              : clock, asynchronous active-low reset
//   if_write_ce/if_write/if_din : write enable, write request, write data
//   if_full_n                 : 1 = space available
//   if_read_ce/if_read        : read enable, read request
//   if_dout, if_empty_n       : head word, 1 = head word valid
//   usedw                     : words stored, 0..DEPTH
module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   usedw
);

  localparam int PW = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] PTR_EMPTY = PTR_EMPTY_CODE[PW-1:0];
  localparam logic [PW-1:0] PTR_NEAR_FULL = PW'(DEPTH - 2);

  if (DEPTH < MIN_DEPTH || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("srl_fifo_ctrl: DEPTH must be in MIN_DEPTH..2**ADDR_WIDTH");
  end

  logic [PW-1:0] m_out_ptr;
  logic          push;
  logic          pop;

  // Gating with the registered flags keeps the pointer from wrapping.
  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read  & if_read_ce  & if_empty_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out_ptr  <= PTR_EMPTY;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
      usedw      <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          m_out_ptr  <= m_out_ptr + PW'(1);
          usedw      <= m_out_ptr + PW'(2);
          if_empty_n <= 1'b1;
          if (m_out_ptr == PTR_NEAR_FULL) begin
            if_full_n <= 1'b0;
          end
        end
        2'b01: begin
          m_out_ptr <= m_out_ptr - PW'(1);
          usedw     <= m_out_ptr;
          if_full_n <= 1'b1;
          if (m_out_ptr == '0) begin
            if_empty_n <= 1'b0;
          end
        end
        default: begin
          // Push with pop: the shift moves the head up by one while the
          // pop retires it, so pointer and flags both hold.
        end
      endcase
    end
  end

  srl_fifo_shiftreg #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_shiftreg (
    .clk (clk),
    .we  (push),
    .addr(m_out_ptr[ADDR_WIDTH-1:0]),
    .din (if_din),
    .dout(if_dout)
  );

endmodule : srl_fifo_ctrl

// File: tb/tb_srl_fifo_ctrl.sv
module tb_srl_fifo_ctrl;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  srl_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) ifs ();
  srl_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ifb ();

  srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) dut_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_write_ce(ifs.write_ce),
    .if_write   (ifs.write),
    .if_din     (ifs.din),
    .if_full_n  (ifs.full_n),
    .if_read_ce (ifs.read_ce),
    .if_read    (ifs.read),
    .if_dout    (ifs.dout),
    .if_empty_n (ifs.empty_n),
    .usedw      (ifs.usedw)
  );

  srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut_big (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_write_ce(ifb.write_ce),
    .if_write   (ifb.write),
    .if_din     (ifb.din),
    .if_full_n  (ifb.full_n),
    .if_read_ce (ifb.read_ce),
    .if_read    (ifb.read),
    .if_dout    (ifb.dout),
    .if_empty_n (ifb.empty_n),
    .usedw      (ifb.usedw)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue per FIFO, capacity limits applied directly.
  logic [7:0] q_s [$];
  logic [7:0] q_b [$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_s.delete();
      q_b.delete();
    end else begin
      bit ps, pp, bs, bp;
      ps = ifs.write && ifs.write_ce && (q_s.size() < 2);
      pp = ifs.read  && ifs.read_ce  && (q_s.size() > 0);
      bs = ifb.write && ifb.write_ce && (q_b.size() < 16);
      bp = ifb.read  && ifb.read_ce  && (q_b.size() > 0);
      if (pp) void'(q_s.pop_front());
      if (ps) q_s.push_back(ifs.din);
      if (bp) void'(q_b.pop_front());
      if (bs) q_b.push_back(ifb.din);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("s_empty_n", 32'(ifs.empty_n), 32'(q_s.size() != 0));
      chk("s_full_n",  32'(ifs.full_n),  32'(q_s.size() != 2));
      chk("s_usedw",   32'(ifs.usedw),   32'(q_s.size()));
      if (q_s.size() != 0) chk("s_dout", 32'(ifs.dout), 32'(q_s[0]));
      chk("b_empty_n", 32'(ifb.empty_n), 32'(q_b.size() != 0));
      chk("b_full_n",  32'(ifb.full_n),  32'(q_b.size() != 16));
      chk("b_usedw",   32'(ifb.usedw),   32'(q_b.size()));
      chk("b_usedw_range", 32'(ifb.usedw <= 5'd16), 32'd1);
      if (q_b.size() != 0) chk("b_dout", 32'(ifb.dout), 32'(q_b[0]));
    end
  end

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_s(input logic w, input logic wce, input logic [7:0] d,
                         input logic r, input logic rce);
    ifs.write    = w;
    ifs.write_ce = wce;
    ifs.din      = d;
    ifs.read     = r;
    ifs.read_ce  = rce;
  endtask

  initial begin
    drive_s(0, 0, 8'h00, 0, 0);
    ifb.write = 0; ifb.write_ce = 0; ifb.din = '0; ifb.read = 0; ifb.read_ce = 0;
    repeat (2) next_cycle();
    reset_n = 1'b1;
    chk("rst_empty_n", 32'(ifs.empty_n), 32'd0);
    chk("rst_full_n",  32'(ifs.full_n),  32'd1);
    chk("rst_usedw",   32'(ifs.usedw),   32'd0);
    next_cycle();

    // Fill to full, overflow write ignored, drain in order.
    drive_s(1, 1, 8'hA1, 0, 0); next_cycle();
    chk("fill1_dout", 32'(ifs.dout), 32'hA1);
    drive_s(1, 1, 8'hB2, 0, 0); next_cycle();
    chk("fill2_full_n", 32'(ifs.full_n), 32'd0);
    chk("fill2_usedw",  32'(ifs.usedw),  32'd2);
    drive_s(1, 1, 8'hC3, 0, 0); next_cycle();
    chk("ovf_usedw", 32'(ifs.usedw), 32'd2);
    chk("ovf_dout",  32'(ifs.dout),  32'hA1);
    drive_s(0, 0, 8'h00, 1, 1); next_cycle();
    chk("rd1_dout",  32'(ifs.dout),  32'hB2);
    chk("rd1_usedw", 32'(ifs.usedw), 32'd1);
    next_cycle();
    chk("rd2_empty_n", 32'(ifs.empty_n), 32'd0);
    chk("rd2_usedw",   32'(ifs.usedw),   32'd0);
    next_cycle();

    // Simultaneous push and pop with one word stored.
    drive_s(1, 1, 8'h11, 0, 0); next_cycle();
    chk("sim_pre_dout", 32'(ifs.dout), 32'h11);
    drive_s(1, 1, 8'h22, 1, 1); next_cycle();
    chk("sim_dout",    32'(ifs.dout),    32'h22);
    chk("sim_usedw",   32'(ifs.usedw),   32'd1);
    chk("sim_empty_n", 32'(ifs.empty_n), 32'd1);
    chk("sim_full_n",  32'(ifs.full_n),  32'd1);
    drive_s(0, 0, 8'h00, 1, 1); next_cycle();
    chk("sim_drain", 32'(ifs.empty_n), 32'd0);

    // Clock-enable gating.
    for (int i = 0; i < 3; i++) begin
      drive_s(1, 0, 8'h77, 0, 0); next_cycle();
      chk("wce_usedw",   32'(ifs.usedw),   32'd0);
      chk("wce_empty_n", 32'(ifs.empty_n), 32'd0);
    end
    drive_s(0, 0, 8'h00, 1, 0); next_cycle();
    chk("rce_usedw", 32'(ifs.usedw), 32'd0);

    // Reset mid-operation with two words stored, pulsed between edges.
    drive_s(1, 1, 8'h01, 0, 0); next_cycle();
    drive_s(1, 1, 8'h02, 0, 0); next_cycle();
    chk("mid_full_n", 32'(ifs.full_n), 32'd0);
    drive_s(0, 0, 8'h00, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("async_empty_n", 32'(ifs.empty_n), 32'd0);
    chk("async_full_n",  32'(ifs.full_n),  32'd1);
    chk("async_usedw",   32'(ifs.usedw),   32'd0);
    #1 reset_n = 1'b1;
    drive_s(1, 1, 8'h5A, 0, 0); next_cycle();
    chk("post_rst_dout",    32'(ifs.dout),    32'h5A);
    chk("post_rst_usedw",   32'(ifs.usedw),   32'd1);
    chk("post_rst_empty_n", 32'(ifs.empty_n), 32'd1);
    drive_s(0, 0, 8'h00, 0, 0); next_cycle();

    // Random stress on the 16-deep FIFO, alternating fill- and drain-biased phases.
    for (int i = 0; i < 10000; i++) begin
      int unsigned wp;
      wp = (((i / 300) % 2) == 0) ? 3 : 1;
      ifb.write    = ($urandom_range(3) < wp);
      ifb.read     = ($urandom_range(3) < (4 - wp));
      ifb.write_ce = ($urandom_range(7) != 0);
      ifb.read_ce  = ($urandom_range(7) != 0);
      ifb.din      = 8'($urandom);
      next_cycle();
    end
    ifb.write = 0; ifb.read = 0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_srl_fifo_ctrl

// File: doc/srl_fifo_ctrl.md
SRL_FIFO_CTRL -- requirements
Module: srl_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1: width of each stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 1: shift-register address width, where DEPTH <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 2: capacity in words, minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port if_write_ce, input, 1 bit: write clock-enable; a write is qualified only when this is 1.
REQ-007 SHALL have port if_write, input, 1 bit: producer write request.
REQ-008 SHALL have port if_din, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have port if_full_n, output, 1 bit: 1 = space available.
REQ-010 SHALL have port if_read_ce, input, 1 bit: read clock-enable; a read is qualified only when this is 1.
REQ-011 SHALL have port if_read, input, 1 bit: consumer read request.
REQ-012 SHALL have port if_dout, output, DATA_WIDTH bits: head-of-queue data.
REQ-013 SHALL have port if_empty_n, output, 1 bit: 1 = if_dout valid.
REQ-014 SHALL have port usedw, output, ADDR_WIDTH+1 bits: current occupancy, 0..DEPTH.

Function
REQ-015 SHALL define push = if_write & if_write_ce & if_full_n and pop = if_read & if_read_ce & if_empty_n; a write while full and a read while empty are ignored with no state change.
REQ-016 SHALL hold a pointer mOutPtr, ADDR_WIDTH+1 bits, where all-ones (-1) means empty and k means k+1 words stored.
REQ-017 SHALL update the pointer as follows: push only, ptr+1; pop only, ptr-1; push and pop together, ptr unchanged; neither, ptr unchanged.
REQ-018 SHALL drive the shift-register we = push; on push the new word enters index 0 and older words move up one index.
REQ-019 SHALL drive the shift-register addr = mOutPtr[ADDR_WIDTH-1:0], so the oldest word is always at addr.
REQ-020 SHALL present if_dout combinationally from shift-register[addr] (first-word fall-through, zero-cycle read latency); if_dout is don't-care when if_empty_n=0.
REQ-021 SHALL keep if_full_n and if_empty_n as registers.
REQ-022 SHALL clear if_full_n on push-only when ptr=DEPTH-2, and set it on pop-only.
REQ-023 SHALL clear if_empty_n on pop-only when ptr=0, and set it on push-only.
REQ-024 SHALL leave both flags unchanged on simultaneous push and pop.
REQ-025 SHALL register usedw with usedw = ptr+1, updated in the same cycle as the pointer.
REQ-026 SHALL keep the pointer from wrapping: full never admits a push and empty never admits a pop.
REQ-027 SHALL make a write into an empty FIFO visible on if_dout, with if_empty_n=1, in the next cycle.

Reset
REQ-028 SHALL, while reset_n=0 and regardless of clk, force mOutPtr to all-ones, if_empty_n=0, if_full_n=1 and usedw=0.
REQ-029 SHALL not reset shift-register contents; asserting reset mid-operation discards all queued words.
REQ-030 SHALL ensure the first push after reset_n deasserts is accepted and then behaves as a push into an empty FIFO.

Structure
REQ-031 SHALL instantiate exactly one sub-module, srl_fifo_shiftreg, with ports clk, we, addr, din and dout, holding storage only (no reset).
REQ-032 SHALL place the pointer empty code (all-ones) and a minimum-depth check constant in the shared package srl_fifo_pkg; no typedefs are needed beyond these.
REQ-033 SHALL, through an elaboration check, reject DEPTH < 2 and DEPTH > 2**ADDR_WIDTH.

Verification (DATA_WIDTH=8, ADDR_WIDTH=1, DEPTH=2 unless stated)
REQ-034 SHALL verify reset: pulse reset_n low between clock edges -> if_empty_n=0, if_full_n=1 and usedw=0 immediately, without waiting for a clock edge.
REQ-035 SHALL verify fill to full: write 0xA1 then 0xB2 on consecutive cycles -> if_full_n=0 and usedw=2; a third write of 0xC3 is ignored; reads return 0xA1 then 0xB2; if_empty_n=0 afterwards.
REQ-036 SHALL verify simultaneous push and pop with one word stored (0x11): write 0x22 and read together -> read returns 0x11, next if_dout=0x22, usedw stays 1, flags unchanged.
REQ-037 SHALL verify clock-enable gating: if_write=1 with if_write_ce=0 for 3 cycles, then if_read=1 with if_read_ce=0 -> no state change and usedw stays 0.
REQ-038 SHALL verify reset mid-operation: with 2 words stored, assert reset_n=0 -> empty state; then write 0x5A -> if_dout=0x5A and usedw=1 next cycle.
REQ-039 SHALL verify a random stress run, with DEPTH=16 and ADDR_WIDTH=4, of 10k cycles of random write/read/ce against a reference queue model -> data order matches, usedw always in 0..16, and no push is accepted while full.
